// File: rtl/fifo_flit_reader.sv
// Read-side consumer of a router input FIFO. It pops head flits, frames them into packets
// from header lengths, and presents them on a valid/ready link with sop/eop, error and packet count.
module fifo_flit_reader #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_read_en,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_rinc,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_sop,
    output logic              o_out_eop,
    output logic              o_pkt_err,
    output logic [CNT_W-1:0]  o_pkt_cnt
);

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_sop;
    logic              r_out_eop;
    logic              r_pkt_err;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic              r_in_pkt;
    logic [LEN_W-1:0]  r_rem;
    logic              r_settle;

    logic              w_accept;
    logic              w_free;
    logic              w_cap;
    logic              w_is_hdr;
    logic [LEN_W-1:0]  w_len;
    logic              w_last;

    assign w_accept = r_out_valid && i_out_ready;
    assign w_free   = !r_out_valid || w_accept;
    // The FIFO read address moves on the pop edge, so rdata is stale for one cycle afterwards.
    assign w_cap    = i_rst && i_read_en && !r_settle && w_free;
    assign w_is_hdr = i_rdata[DATA_W-1];
    assign w_len    = i_rdata[LEN_W-1:0];
    assign w_last   = (r_rem == LEN_W'(1));

    assign o_rinc      = w_cap;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_sop   = r_out_sop;
    assign o_out_eop   = r_out_eop;
    assign o_pkt_err   = r_pkt_err;
    assign o_pkt_cnt   = r_pkt_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_pkt_cnt   <= '0;
            r_in_pkt    <= 1'b0;
            r_rem       <= '0;
            r_settle    <= 1'b0;
        end else begin
            r_settle <= w_cap;

            if (w_accept) begin
                r_out_valid <= 1'b0;
                if (r_out_eop) begin
                    r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                end
            end

            if (w_cap) begin
                if (!r_in_pkt) begin
                    if (w_is_hdr) begin
                        r_out_data  <= i_rdata;
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b1;
                        r_out_eop   <= (w_len == '0);
                        r_in_pkt    <= (w_len != '0);
                        r_rem       <= w_len;
                    end else begin
                        // Orphan payload: popped and dropped, output entry untouched.
                        r_pkt_err <= 1'b1;
                    end
                end else begin
                    r_out_data  <= i_rdata;
                    r_out_valid <= 1'b1;
                    r_out_sop   <= 1'b0;
                    r_out_eop   <= w_last;
                    r_rem       <= r_rem - LEN_W'(1);
                    if (w_last) begin
                        r_in_pkt <= 1'b0;
                    end
                    if (w_is_hdr) begin
                        r_pkt_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
